// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing types, mode presets and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  typedef struct packed {
    vga_timing_t h;
    vga_timing_t v;
  } vga_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam vga_mode_t VGA_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33}
  };

  localparam vga_mode_t SVGA_800x600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
  };

  function automatic int unsigned timing_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module   : vga_delay_line
// Purpose  : WIDTH x DEPTH shift register with synchronous clear; DEPTH 0 is a wire.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             vga_clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = vga_clk ^ clr;
    assign q        = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge vga_clk) begin
      if (clr) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          r_stage[i] <= '0;
        end
      end else begin
        r_stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign q = r_stage[DEPTH-1];
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing with pixel-fetch port and
//            latency-aligned registered DAC outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_640x480_60.h.active,
  parameter int unsigned H_FP        = VGA_640x480_60.h.fp,
  parameter int unsigned H_SYNC      = VGA_640x480_60.h.sync,
  parameter int unsigned H_BP        = VGA_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE    = VGA_640x480_60.v.active,
  parameter int unsigned V_FP        = VGA_640x480_60.v.fp,
  parameter int unsigned V_SYNC      = VGA_640x480_60.v.sync,
  parameter int unsigned V_BP        = VGA_640x480_60.v.bp,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned PIX_LATENCY = 2,
  parameter int unsigned COORD_W     = 12,
  parameter int unsigned COLOR_W     = 8
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_req,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic               vga_clk_out,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count
);

  localparam vga_timing_t c_h_tim = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t c_v_tim = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned c_h_total = timing_total(c_h_tim);
  localparam int unsigned c_v_total = timing_total(c_v_tim);

  localparam logic [COORD_W-1:0] c_h_last   = COORD_W'(c_h_total - 1);
  localparam logic [COORD_W-1:0] c_v_last   = COORD_W'(c_v_total - 1);
  localparam logic [COORD_W-1:0] c_h_act    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] c_v_act    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] c_hs_first = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] c_hs_last  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] c_vs_first = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] c_vs_last  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: every porch and sync width must be at least 1");
  end
  if (PIX_LATENCY > 4) begin : g_bad_latency
    $error("vga_timing_gen: PIX_LATENCY must be in 0..4");
  end
  if (c_h_total >= 2**COORD_W || c_v_total >= 2**COORD_W) begin : g_bad_width
    $error("vga_timing_gen: line/frame totals do not fit in COORD_W");
  end

  logic               w_run;
  logic               w_h_end;
  logic               w_v_end;
  logic               w_hs;
  logic               w_vs;
  logic [2:0]         w_dly;
  logic [COORD_W-1:0] r_h;
  logic [COORD_W-1:0] r_v;
  logic [15:0]        r_frame_count;

  // en low is treated exactly like reset so a PLL losing lock restarts cleanly
  assign w_run   = rst_n & en;
  assign w_h_end = (r_h == c_h_last);
  assign w_v_end = (r_v == c_v_last);

  always_ff @(posedge vga_clk) begin
    if (!w_run) begin
      r_h           <= '0;
      r_v           <= '0;
      r_frame_count <= '0;
    end else if (w_h_end) begin
      r_h <= '0;
      if (w_v_end) begin
        r_v           <= '0;
        r_frame_count <= r_frame_count + 16'd1;
      end else begin
        r_v <= r_v + 1'b1;
      end
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign pix_x       = r_h;
  assign pix_y       = r_v;
  assign pix_req     = (r_h < c_h_act) && (r_v < c_v_act);
  assign frame_count = r_frame_count;
  assign line_start  = w_run && (r_h == '0);
  assign frame_start = line_start && (r_v == '0);

  assign w_hs = (r_h >= c_hs_first) && (r_h <= c_hs_last);
  assign w_vs = (r_v >= c_vs_first) && (r_v <= c_vs_last);

  // Sync/blank flags travel with the pixel source latency; flags are stored active-high
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LATENCY)
  ) u_sync_dly (
    .vga_clk (vga_clk),
    .clr     (~w_run),
    .d       ({w_hs, w_vs, pix_req}),
    .q       (w_dly)
  );

  always_ff @(posedge vga_clk) begin
    if (!w_run) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_blank_n <= 1'b0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
    end else begin
      vga_r       <= w_dly[0] ? pix_r : '0;
      vga_g       <= w_dly[0] ? pix_g : '0;
      vga_b       <= w_dly[0] ? pix_b : '0;
      vga_blank_n <= w_dly[0];
      vga_hs      <= w_dly[2] ? HS_POL : ~HS_POL;
      vga_vs      <= w_dly[1] ? VS_POL : ~VS_POL;
    end
  end

  assign vga_sync_n  = 1'b0;
  assign vga_clk_out = vga_clk;

endmodule

`default_nettype wire
